weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/systolic_pkg.sv | 33 +++
 rtl/weight_loader.sv | 186 ++++++++++++++++++
 tb/tb_weight_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Definitions shared by the systolic-array blocks:
//   ARRAY_DIM / WEIGHT_W / WMEM_AW : default array edge, lane width and
//                                    weight-memory address width
//   FLAG_IDLE / FLAG_SHIFT / FLAG_COMMIT : MMU weight-control encodings
//   wl_state_e                     : weight_loader FSM states
//   clamp_size()                   : clamps a requested tile size to the array
// ---------------------------------------------------------------------------
package systolic_pkg;

  localparam int ARRAY_DIM = 16;
  localparam int WEIGHT_W  = 8;
  localparam int WMEM_AW   = 10;

  localparam logic [1:0] FLAG_IDLE   = 2'b00;
  localparam logic [1:0] FLAG_SHIFT  = 2'b01;
  localparam logic [1:0] FLAG_COMMIT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } wl_state_e;

  // Oversized requests are treated as a full-array tile.
  function automatic logic [4:0] clamp_size(input logic [4:0] sz,
                                            input logic [4:0] max_sz);
    return (sz > max_sz) ? max_sz : sz;
  endfunction

endpackage : systolic_pkg

// File: rtl/weight_loader.sv
// ---------------------------------------------------------------------------
// weight_loader
// Streams one NxN weight tile from the weight memory into the MMU, last row
// first, then commits it.
//
// Ports
//   clk         : sole clock, rising edge
//   rst         : asynchronous, active-low reset
//   start       : load request, only looked at while idle
//   gemm_size   : tile size N (0 -> commit only, >ARRAY_DIM -> ARRAY_DIM)
//   base_addr   : address of tile row 0
//   wmem_rd     : weight memory read strobe
//   wmem_addr   : weight memory read address (0 when not reading)
//   wmem_data   : read data, valid the cycle after wmem_rd; lane i at
//                 [WEIGHT_W*i +: WEIGHT_W]
//   weight1..16 : row lanes to the MMU, zero unless flag is SHIFT
//   flag        : 00 idle, 01 shift row in, 10 commit tile
//   busy        : high from the cycle after start through the commit cycle
//   done        : one-cycle pulse with the commit
//
// Build option
//   WEIGHT_LOADER_COL_MASK_EN : when defined, lanes with index >= N are
//                               forced to zero during shift cycles.
// ---------------------------------------------------------------------------
module weight_loader #(
  parameter int ARRAY_DIM = systolic_pkg::ARRAY_DIM,
  parameter int WEIGHT_W  = systolic_pkg::WEIGHT_W,
  parameter int WMEM_AW   = systolic_pkg::WMEM_AW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [4:0]                    gemm_size,
  input  logic [WMEM_AW-1:0]            base_addr,
  output logic                          wmem_rd,
  output logic [WMEM_AW-1:0]            wmem_addr,
  input  logic [ARRAY_DIM*WEIGHT_W-1:0] wmem_data,
  output logic [WEIGHT_W-1:0]           weight1,
  output logic [WEIGHT_W-1:0]           weight2,
  output logic [WEIGHT_W-1:0]           weight3,
  output logic [WEIGHT_W-1:0]           weight4,
  output logic [WEIGHT_W-1:0]           weight5,
  output logic [WEIGHT_W-1:0]           weight6,
  output logic [WEIGHT_W-1:0]           weight7,
  output logic [WEIGHT_W-1:0]           weight8,
  output logic [WEIGHT_W-1:0]           weight9,
  output logic [WEIGHT_W-1:0]           weight10,
  output logic [WEIGHT_W-1:0]           weight11,
  output logic [WEIGHT_W-1:0]           weight12,
  output logic [WEIGHT_W-1:0]           weight13,
  output logic [WEIGHT_W-1:0]           weight14,
  output logic [WEIGHT_W-1:0]           weight15,
  output logic [WEIGHT_W-1:0]           weight16,
  output logic [1:0]                    flag,
  output logic                          busy,
  output logic                          done
);
  import systolic_pkg::*;

  // The MMU interface has a fixed set of 16 lane ports.
  localparam int NUM_LANES = 16;

  wl_state_e          state_reg, state_next;
  logic [4:0]         n_clamp;
  logic [4:0]         cnt_reg;
  logic [WMEM_AW-1:0] addr_reg;
  logic               rd_valid_reg;   // a read was issued last cycle
  logic               shift_en;
  logic [WEIGHT_W-1:0] lane_out [NUM_LANES];

`ifdef WEIGHT_LOADER_COL_MASK_EN
  logic [4:0]         n_reg;
`endif

  assign n_clamp = clamp_size(gemm_size, 5'(ARRAY_DIM));

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // ---------------- next state and outputs ----------------
  always_comb begin
    state_next = state_reg;
    wmem_rd    = 1'b0;
    wmem_addr  = '0;
    flag       = FLAG_IDLE;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = (n_clamp == 5'd0) ? ST_COMMIT : ST_RUN;
      end
      ST_RUN: begin
        wmem_rd   = 1'b1;
        wmem_addr = addr_reg;
        busy      = 1'b1;
        // First RUN cycle has no returned row yet.
        flag      = rd_valid_reg ? FLAG_SHIFT : FLAG_IDLE;
        if (cnt_reg == 5'd0) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Receives the row for the final (base_addr) read.
        busy       = 1'b1;
        flag       = FLAG_SHIFT;
        state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy       = 1'b1;
        done       = 1'b1;
        flag       = FLAG_COMMIT;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- address / row counter ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg      <= '0;
      addr_reg     <= '0;
      rd_valid_reg <= 1'b0;
`ifdef WEIGHT_LOADER_COL_MASK_EN
      n_reg        <= '0;
`endif
    end else begin
      rd_valid_reg <= (state_reg == ST_RUN);
      if (state_reg == ST_IDLE && start) begin
        // Walk from the last row down to row 0; wraps modulo 2^WMEM_AW.
        // For N=0 the counter is never used.
        cnt_reg  <= n_clamp - 5'd1;
        addr_reg <= base_addr + WMEM_AW'(n_clamp) - WMEM_AW'(1);
`ifdef WEIGHT_LOADER_COL_MASK_EN
        n_reg    <= n_clamp;
`endif
      end else if (state_reg == ST_RUN) begin
        cnt_reg  <= cnt_reg - 5'd1;
        addr_reg <= addr_reg - WMEM_AW'(1);
      end
    end
  end

  // ---------------- lane steering ----------------
  // Memory data already carries the 1-cycle latency, so rows are forwarded
  // combinationally while flag is SHIFT and zeroed otherwise.
  assign shift_en = (flag == FLAG_SHIFT);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [WEIGHT_W-1:0] lane_raw;
    logic                lane_keep;

    if (gi < ARRAY_DIM) begin : g_present
      assign lane_raw = wmem_data[gi*WEIGHT_W +: WEIGHT_W];
    end else begin : g_absent
      assign lane_raw = '0;
    end

`ifdef WEIGHT_LOADER_COL_MASK_EN
    assign lane_keep = (5'(gi) < n_reg);
`else
    assign lane_keep = 1'b1;
`endif

    assign lane_out[gi] = (shift_en && lane_keep) ? lane_raw : '0;
  end

  assign weight1  = lane_out[0];
  assign weight2  = lane_out[1];
  assign weight3  = lane_out[2];
  assign weight4  = lane_out[3];
  assign weight5  = lane_out[4];
  assign weight6  = lane_out[5];
  assign weight7  = lane_out[6];
  assign weight8  = lane_out[7];
  assign weight9  = lane_out[8];
  assign weight10 = lane_out[9];
  assign weight11 = lane_out[10];
  assign weight12 = lane_out[11];
  assign weight13 = lane_out[12];
  assign weight14 = lane_out[13];
  assign weight15 = lane_out[14];
  assign weight16 = lane_out[15];

endmodule : weight_loader

// File: tb/tb_weight_loader.sv
// ---------------------------------------------------------------------------
// tb_weight_loader
// Directed, table-driven bench for weight_loader. A behavioural weight memory
// returns a per-address row one cycle after each read; every load is checked
// cycle by cycle against the documented timing, followed by hand-written
// reset-abort sequences.
// ---------------------------------------------------------------------------
module tb_weight_loader;

  localparam int AD = 16;
  localparam int WW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    gemm_size = '0;
  logic [AW-1:0] base_addr = '0;
  logic          wmem_rd;
  logic [AW-1:0] wmem_addr;
  logic [AD*WW-1:0] wmem_data = '0;
  logic [WW-1:0] weight1, weight2, weight3, weight4, weight5, weight6, weight7, weight8;
  logic [WW-1:0] weight9, weight10, weight11, weight12, weight13, weight14, weight15, weight16;
  logic [1:0]    flag;
  logic          busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  bit mem_all_ab = 1'b0;

  weight_loader dut (
    .clk(clk), .rst(rst), .start(start), .gemm_size(gemm_size), .base_addr(base_addr),
    .wmem_rd(wmem_rd), .wmem_addr(wmem_addr), .wmem_data(wmem_data),
    .weight1(weight1), .weight2(weight2), .weight3(weight3), .weight4(weight4),
    .weight5(weight5), .weight6(weight6), .weight7(weight7), .weight8(weight8),
    .weight9(weight9), .weight10(weight10), .weight11(weight11), .weight12(weight12),
    .weight13(weight13), .weight14(weight14), .weight15(weight15), .weight16(weight16),
    .flag(flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory contents: lane i of address a = a[7:0] ^ (i<<4) ^ a[9:8].
  function automatic logic [AD*WW-1:0] mem_row(input logic [AW-1:0] a);
    logic [AD*WW-1:0] r;
    for (int i = 0; i < AD; i++) begin
      if (mem_all_ab) r[i*WW +: WW] = 8'hAB;
      else            r[i*WW +: WW] = a[7:0] ^ 8'(i * 16) ^ {6'b0, a[9:8]};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (wmem_rd) wmem_data <= mem_row(wmem_addr);
  end

  wire [AD*WW-1:0] w_all = {weight16, weight15, weight14, weight13, weight12, weight11,
                            weight10, weight9, weight8, weight7, weight6, weight5,
                            weight4, weight3, weight2, weight1};
  wire [14:0] ctrl_all = {wmem_rd, wmem_addr, flag, busy, done};

  task automatic chk(input string name, input logic [AD*WW-1:0] act,
                     input logic [AD*WW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [4:0]    gemm;
    logic [AW-1:0] base;
    int            exp_n;     // effective tile size after clamping
    int            inject_k;  // cycle T+k to pulse a stray start (0 = none)
    bit            use_ab;    // memory returns 0xAB on every lane
  } vec_t;

  vec_t vecs[8];

  task automatic run_load(input vec_t v, input int idx);
    int  n = v.exp_n;
    int  commit_k = (n == 0) ? 1 : n + 2;
    int  rd_cnt = 0;
    int  done_cnt = 0;
    logic        e_rd, e_busy, e_done;
    logic [AW-1:0] e_addr;
    logic [1:0]  e_flag;
    logic [AD*WW-1:0] e_w;

    @(posedge clk); #1;
    mem_all_ab = v.use_ab;
    start = 1'b1; gemm_size = v.gemm; base_addr = v.base;
    @(posedge clk); #1;            // edge T sampled start; now in cycle T+1
    start = 1'b0;
    for (int k = 1; k <= n + 4; k++) begin
      e_rd   = (k <= n);
      e_addr = e_rd ? AW'(int'(v.base) + n - k) : '0;
      e_flag = (k == commit_k) ? 2'b10 : ((k >= 2 && k <= n + 1) ? 2'b01 : 2'b00);
      e_busy = (k <= commit_k);
      e_done = (k == commit_k);
      e_w    = '0;
      if (e_flag == 2'b01) begin
        e_w = mem_row(AW'(int'(v.base) + n - (k - 1)));
`ifdef WEIGHT_LOADER_COL_MASK_EN
        for (int i = 0; i < AD; i++) if (i >= n) e_w[i*WW +: WW] = '0;
`endif
      end
      chk($sformatf("v%0d ctrl T+%0d", idx, k), 128'(ctrl_all),
          128'({e_rd, e_addr, e_flag, e_busy, e_done}));
      chk($sformatf("v%0d weights T+%0d", idx, k), w_all, e_w);
      if (wmem_rd) rd_cnt++;
      if (done) done_cnt++;
      if (k == v.inject_k) begin
        start = 1'b1; gemm_size = 5'd7; base_addr = 10'h155;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk($sformatf("v%0d read count", idx), 128'(rd_cnt), 128'(n));
    chk($sformatf("v%0d done count", idx), 128'(done_cnt), 128'(1));
    $display("load %0d: N=%0d base=%h eff_N=%0d reads=%0d dones=%0d", idx, v.gemm, v.base,
             n, rd_cnt, done_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{gemm: 5'd4,  base: 10'h010, exp_n: 4,  inject_k: 0, use_ab: 1'b0};
    vecs[1] = '{gemm: 5'd16, base: 10'h3FE, exp_n: 16, inject_k: 0, use_ab: 1'b0};
    vecs[2] = '{gemm: 5'd3,  base: 10'h050, exp_n: 3,  inject_k: 0, use_ab: 1'b1};
    vecs[3] = '{gemm: 5'd4,  base: 10'h020, exp_n: 4,  inject_k: 3, use_ab: 1'b0};
    vecs[4] = '{gemm: 5'd0,  base: 10'h0C0, exp_n: 0,  inject_k: 0, use_ab: 1'b0};
    vecs[5] = '{gemm: 5'd20, base: 10'h200, exp_n: 16, inject_k: 0, use_ab: 1'b0};
    vecs[6] = '{gemm: 5'd1,  base: 10'h3FF, exp_n: 1,  inject_k: 0, use_ab: 1'b0};
    vecs[7] = '{gemm: 5'd2,  base: 10'h0A5, exp_n: 2,  inject_k: 0, use_ab: 1'b0};

    // Reset state while rst is held low.
    #2;
    chk("reset ctrl", 128'(ctrl_all), 128'(0));
    chk("reset weights", w_all, '0);
    $display("reset: ctrl=%h", ctrl_all);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 7; i++) run_load(vecs[i], i);

    // Abort an N=8 load with reset during cycle T+3.
    @(posedge clk); #1;
    mem_all_ab = 1'b0;
    start = 1'b1; gemm_size = 5'd8; base_addr = 10'h100;
    @(posedge clk); #1; start = 1'b0;     // T+1
    @(posedge clk); #1;                   // T+2
    @(posedge clk); #1;                   // T+3
    chk("abort pre-reset busy", 128'(busy), 128'(1));
    rst = 1'b0;
    #1;
    chk("abort ctrl zero", 128'(ctrl_all), 128'(0));
    chk("abort weights zero", w_all, '0);
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post-abort idle c%0d", k), 128'(ctrl_all), 128'(0));
    end
    $display("abort: N=8 load reset at T+3, ctrl=%h", ctrl_all);

    // A fresh load after the abort completes normally.
    run_load(vecs[7], 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_weight_loader
